// File: rtl/div_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl_pkg
// Shared definitions for the EX-stage divider issue controller:
//   - controller state encoding
//   - divider start-level constants (DivStart / DivStop)
//   - DIV operation codes as seen on ex_div_op_i
//   - helper that picks quotient or remainder out of the divider result
// -----------------------------------------------------------------------------
package div_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } div_state_e;

    // Level driven on the divider's start input.
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // Operation codes: bit 1 = unsigned, bit 0 = remainder.
    localparam logic [1:0] DIV_OP_DIV_W  = 2'b00;
    localparam logic [1:0] DIV_OP_MOD_W  = 2'b01;
    localparam logic [1:0] DIV_OP_DIV_WU = 2'b10;
    localparam logic [1:0] DIV_OP_MOD_WU = 2'b11;

    // Number of cycles spent in DRAIN after an annul, minus one.
    localparam logic [1:0] DRAIN_LAST = 2'd1;

    // Divider result is {remainder, quotient}; sel_rem picks the upper half.
    function automatic logic [31:0] select_result(input logic        sel_rem,
                                                  input logic [63:0] res);
        logic [31:0] sel_s;
        if (sel_rem) begin
            sel_s = res[63:32];
        end else begin
            sel_s = res[31:0];
        end
        return sel_s;
    endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
// Initiator-side controller for the iterative 32-bit divider in EX. Latches
// the operands of a div/mod instruction, holds start to the divider until it
// reports ready, returns the selected quotient/remainder and releases the
// divider. A flush while the divider is busy annuls it and waits out a short
// drain so the divider is back in its free state before the next issue.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   ex_valid_i            EX holds a valid instruction
//   ex_is_div_i           EX instruction is div.w/mod.w/div.wu/mod.wu
//   ex_div_op_i[1:0]      operation code
//   ex_src1_i/ex_src2_i   dividend / divisor
//   flush_i               pipeline flush, kills the EX instruction
//   out_ready_i           EX may hand its result downstream
//   stall_o               EX must hold
//   div_valid_o           div_result_o is valid
//   div_result_o[31:0]    selected quotient or remainder
//   signed_div_o          to divider: signed operation
//   opdata1_o/opdata2_o   to divider: operands (frozen while busy)
//   start_o, annul_o      to divider: handshake
//   div_res_i[63:0]       from divider: {remainder, quotient}
//   div_ready_i           from divider: result available
// -----------------------------------------------------------------------------
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid_i,
    input  logic        ex_is_div_i,
    input  logic [1:0]  ex_div_op_i,
    input  logic [31:0] ex_src1_i,
    input  logic [31:0] ex_src2_i,
    input  logic        flush_i,
    input  logic        out_ready_i,
    output logic        stall_o,
    output logic        div_valid_o,
    output logic [31:0] div_result_o,
    output logic        signed_div_o,
    output logic [31:0] opdata1_o,
    output logic [31:0] opdata2_o,
    output logic        start_o,
    output logic        annul_o,
    input  logic [63:0] div_res_i,
    input  logic        div_ready_i
);

    div_state_e  state_r;
    logic        sel_rem_r;
    logic [1:0]  drain_cnt_r;
    logic        div_req_s;
    logic        issue_s;

    assign div_req_s = ex_valid_i & ex_is_div_i & ~flush_i;
    // A still-high ready belongs to the previous operation; never issue on it.
    assign issue_s   = div_req_s & ~div_ready_i;
    assign stall_o   = div_req_s & (state_r != ST_DONE);

    // Issue FSM with operand/result register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            sel_rem_r    <= 1'b0;
            drain_cnt_r  <= 2'd0;
            div_valid_o  <= 1'b0;
            div_result_o <= 32'd0;
            signed_div_o <= 1'b0;
            opdata1_o    <= 32'd0;
            opdata2_o    <= 32'd0;
            start_o      <= DivStop;
            annul_o      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        opdata1_o    <= ex_src1_i;
                        opdata2_o    <= ex_src2_i;
                        signed_div_o <= ~ex_div_op_i[1];
                        sel_rem_r    <= ex_div_op_i[0];
                        start_o      <= DivStart;
                        state_r      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Operands stay frozen: the divider reads them again
                    // during its final sign correction.
                    if (flush_i) begin
                        start_o     <= DivStop;
                        annul_o     <= 1'b1;
                        drain_cnt_r <= 2'd0;
                        state_r     <= ST_DRAIN;
                    end else if (div_ready_i) begin
                        div_result_o <= select_result(sel_rem_r, div_res_i);
                        div_valid_o  <= 1'b1;
                        start_o      <= DivStop;
                        state_r      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i | flush_i) begin
                        div_valid_o <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // Two cycles let a divider caught in DivByZero/DivEnd
                    // observe the annul and fall back to free.
                    annul_o <= 1'b0;
                    if (drain_cnt_r == DRAIN_LAST) begin
                        drain_cnt_r <= 2'd0;
                        state_r     <= ST_IDLE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    start_o     <= DivStop;
                    annul_o     <= 1'b0;
                    div_valid_o <= 1'b0;
                    drain_cnt_r <= 2'd0;
                end
            endcase
        end
    end

endmodule
